// File: rtl/test_sequencer.sv
// Test sequencer: arms a set of tester ports, runs the generators for a
// programmed number of cycles, lets the checkers drain, then captures the
// per-port checker results. Start/stop strobes are decoded from the
// registered FSM state in the cycle they take effect and are masked by rst.
module test_sequencer #(
  parameter int NUM_PORTS    = 4,
  parameter int DRAIN_CYCLES = 1024,
  parameter int DUR_WIDTH    = 32,
  parameter int RESULT_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cmd_start,
  input  logic                                   cmd_abort,
  input  logic [DUR_WIDTH-1:0]                   cmd_duration,
  input  logic [NUM_PORTS-1:0]                   cmd_port_mask,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   aborted,
  output logic [DUR_WIDTH-1:0]                   elapsed,
  input  logic [NUM_PORTS-1:0]                   gen_ready,
  input  logic [NUM_PORTS-1:0]                   chk_ready,
  output logic [NUM_PORTS-1:0]                   gen_start,
  output logic [NUM_PORTS-1:0]                   gen_stop,
  output logic [NUM_PORTS-1:0]                   chk_start,
  output logic [NUM_PORTS-1:0]                   chk_stop,
  input  logic [NUM_PORTS-1:0][RESULT_WIDTH-1:0] chk_result,
  output logic [NUM_PORTS-1:0][RESULT_WIDTH-1:0] result_out,
  output logic [2:0]                             state_dbg
);

  // Handshake: a masked port is "ready" when both its gen_ready and
  // chk_ready are high. The start strobes fire in the first cycle in which
  // every masked port is ready; there is no backpressure on the strobes
  // themselves, each is a single-cycle pulse that the port must accept.

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_RUN        = 3'd2,
    S_DRAIN      = 3'd3,
    S_CAPTURE    = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  // A drain of 0 or 1 cycles both stop the checkers in the first DRAIN cycle.
  localparam logic [31:0]          DRAIN_LAST = (DRAIN_CYCLES > 1) ? 32'(DRAIN_CYCLES - 1) : 32'd0;
  localparam logic [DUR_WIDTH-1:0] DUR_ONE    = DUR_WIDTH'(1);

  state_t               state;
  logic [DUR_WIDTH-1:0] dur_q;
  logic [NUM_PORTS-1:0] mask_q;
  logic [31:0]          drain_cnt;

  logic ready_ok;
  logic run_last;
  logic drain_last;
  logic start_fire;
  logic gen_stop_fire;
  logic chk_stop_fire;

  assign busy      = (state == S_WAIT_READY) || (state == S_RUN) ||
                     (state == S_DRAIN) || (state == S_CAPTURE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Event decode: which strobes the current state and commands call for.
  always_comb begin
    ready_ok      = ((gen_ready & chk_ready & mask_q) == mask_q);
    run_last      = (state == S_RUN) && (elapsed == dur_q - DUR_ONE);
    drain_last    = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
    start_fire    = (state == S_WAIT_READY) && ready_ok && !cmd_abort;
    gen_stop_fire = ((state == S_WAIT_READY) && cmd_abort) ||
                    ((state == S_RUN) && (run_last || cmd_abort));
    chk_stop_fire = (((state == S_WAIT_READY) || (state == S_RUN)) && cmd_abort) ||
                    ((state == S_DRAIN) && (drain_last || cmd_abort));
  end

  // Per-port strobes, confined to the latched mask and suppressed under rst.
  always_comb begin
    gen_start = '0;
    chk_start = '0;
    gen_stop  = '0;
    chk_stop  = '0;
    if (!rst) begin
      if (start_fire) begin
        gen_start = mask_q;
        chk_start = mask_q;
      end
      if (gen_stop_fire) gen_stop = mask_q;
      if (chk_stop_fire) chk_stop = mask_q;
    end
  end

  // Sequencer FSM with its latched command, counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      dur_q      <= '0;
      mask_q     <= '0;
      drain_cnt  <= '0;
      aborted    <= 1'b0;
      elapsed    <= '0;
      result_out <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // An empty mask is not a test; the abort line is irrelevant here.
          if (cmd_start && (cmd_port_mask != '0)) begin
            dur_q   <= (cmd_duration == '0) ? DUR_ONE : cmd_duration;
            mask_q  <= cmd_port_mask;
            aborted <= 1'b0;
            elapsed <= '0;
            state   <= S_WAIT_READY;
          end
        end
        S_WAIT_READY: begin
          if (cmd_abort) begin
            aborted <= 1'b1;
            state   <= S_CAPTURE;
          end else if (ready_ok) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Every RUN cycle counts, including the one that ends the run.
          if (elapsed != '1) elapsed <= elapsed + DUR_ONE;
          if (cmd_abort) begin
            aborted <= 1'b1;
            state   <= S_CAPTURE;
          end else if (run_last) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cmd_abort) begin
            aborted <= 1'b1;
            state   <= S_CAPTURE;
          end else if (drain_last) begin
            state <= S_CAPTURE;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        S_CAPTURE: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            result_out[i] <= mask_q[i] ? chk_result[i] : '0;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of tester ports sequenced.
REQ-002 Parameter DRAIN_CYCLES, default 1024, cycles between generator stop and checker stop.
REQ-003 Parameter DUR_WIDTH, default 32, width of the test duration and elapsed counters.
REQ-004 clk  in  1  single clock; every signal is synchronous to it.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_start  in  1  one-cycle request to begin a test.
REQ-007 cmd_abort  in  1  one-cycle request to end a running test early.
REQ-008 cmd_duration  in  DUR_WIDTH  generator run time in cycles, sampled with cmd_start.
REQ-009 cmd_port_mask  in  NUM_PORTS  ports taking part, sampled with cmd_start.
REQ-010 busy  out  1  test in progress.
REQ-011 done  out  1  results valid; held until the next accepted start or rst.
REQ-012 aborted  out  1  last test ended by cmd_abort; valid while done=1.
REQ-013 elapsed  out  DUR_WIDTH  cycles spent in RUN for the last test.
REQ-014 gen_ready, chk_ready  in  NUM_PORTS each  per-port generator and checker ready.
REQ-015 gen_start, gen_stop, chk_start, chk_stop  out  NUM_PORTS each  per-port one-cycle control pulses.
REQ-016 chk_result  in  NUM_PORTS x port_result_t  live per-port checker results.
REQ-017 result_out  out  NUM_PORTS x port_result_t  captured per-port results.

Function
REQ-018 FSM states: IDLE, WAIT_READY, RUN, DRAIN, CAPTURE, DONE.
REQ-019 IDLE/DONE: cmd_start with cmd_port_mask != 0 SHALL latch duration and mask, clear done, aborted and elapsed, and move to WAIT_READY; cmd_start with mask == 0 is ignored.
REQ-020 A cmd_duration of 0 SHALL be treated as 1.
REQ-021 WAIT_READY: when every masked bit of gen_ready and chk_ready is 1, gen_start and chk_start SHALL pulse on the masked bits in that cycle (cycle T), and the FSM moves to RUN.
REQ-022 RUN: gen_stop SHALL pulse on the masked bits in cycle T+D (D = latched duration), and the FSM moves to DRAIN.
REQ-023 elapsed SHALL increment once per RUN cycle, saturating at all-ones.
REQ-024 DRAIN: after DRAIN_CYCLES cycles in DRAIN, chk_stop SHALL pulse on the masked bits, and the FSM moves to CAPTURE.
REQ-025 DRAIN_CYCLES = 0: chk_stop SHALL pulse in the cycle after gen_stop.
REQ-026 CAPTURE: one cycle after chk_stop, result_out SHALL load chk_result for masked ports and zero for unmasked ports; the FSM then moves to DONE.
REQ-027 DONE: done=1, busy=0.
REQ-028 busy SHALL be 1 exactly in WAIT_READY, RUN, DRAIN and CAPTURE.
REQ-029 cmd_start SHALL be ignored while busy=1.
REQ-030 cmd_abort in WAIT_READY, RUN or DRAIN SHALL:
- pulse gen_stop and chk_stop on the masked bits in the same cycle;
- set aborted=1;
- move to CAPTURE.
REQ-031 cmd_abort SHALL be ignored in IDLE, CAPTURE and DONE.
REQ-032 If cmd_start and cmd_abort arrive in the same cycle in IDLE/DONE, the start SHALL be accepted and the abort ignored.
REQ-033 If cmd_abort arrives in the cycle where gen_stop would fire, the abort SHALL take precedence; gen_stop SHALL still pulse exactly once.
REQ-034 No start/stop output SHALL assert more than one cycle per test, and no unmasked bit SHALL ever assert.
REQ-035 cmd_port_mask and cmd_duration changes after acceptance SHALL have no effect on a running test.

Reset
REQ-036 rst SHALL return the FSM to IDLE in the next cycle from any state, including mid-RUN and mid-DRAIN.
REQ-037 Reset values: busy=0, done=0, aborted=0, elapsed=0, result_out=0, all start/stop outputs 0.
REQ-038 A start/stop pulse coincident with rst SHALL be suppressed.

Verification
REQ-039 Normal test: mask=4'b0101, D=100, DRAIN_CYCLES=16, all ready -> start pulse on bits 0,2 at T; gen_stop at T+100; chk_stop at T+116; done=1 at T+118; elapsed=100; result_out[1]=result_out[3]=0.
REQ-040 Ready stall: chk_ready[2]=0 for 50 cycles -> no start pulse until the cycle chk_ready[2] rises; busy=1 throughout the wait.
REQ-041 Abort: cmd_abort 40 cycles into RUN with D=100 -> gen_stop and chk_stop in the same cycle; aborted=1; elapsed=40; done two cycles later.
REQ-042 Ignored commands: mask=0 start -> stays IDLE; second cmd_start during RUN -> no new start pulses, and D and mask are unchanged.
REQ-043 Reset mid-DRAIN -> IDLE next cycle, all outputs at reset values, no chk_stop emitted; a new test then runs normally.
REQ-044 Back-to-back: cmd_start in the DONE cycle -> done clears next cycle and the second test's results replace the first's.
